// File: rtl/servo_pkg.sv
// Shared definitions for the multi-channel servo PWM controller.
// Holds default parameter values, the on-time type, the counter width derivation and the
// angle-to-on-time conversion used by both the top level and the per-channel logic.
package servo_pkg;

  localparam int unsigned DefNumCh     = 6;
  localparam int unsigned DefAngleW    = 8;
  localparam int unsigned DefMaxAngle  = 180;
  localparam int unsigned DefPeriodCyc = 2000000;
  localparam int unsigned DefMinOn     = 50000;
  localparam int unsigned DefStepCyc   = 1000;
  localparam int unsigned DefSlewCyc   = 5000;

  // On-times are kept 32 bits wide so any legal frame length fits without overflow.
  localparam int unsigned OnW = 32;
  typedef logic [OnW-1:0] on_time_t;

  // Bits needed for a counter running 0..period-1.
  function automatic int unsigned cnt_width(input int unsigned period);
    return (period > 1) ? $clog2(period) : 1;
  endfunction

  // Clamp the angle, then map it linearly onto an on-time in clock cycles.
  function automatic on_time_t angle_to_on(input int unsigned angle,
                                           input int unsigned max_angle,
                                           input int unsigned min_on,
                                           input int unsigned step);
    int unsigned a;
    a = (angle > max_angle) ? max_angle : angle;
    return on_time_t'(min_on + a * step);
  endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo channel: target register, per-frame slew-limited active on-time, latched enable
// and the registered PWM compare against the shared frame counter.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   frame_end   - high on the cycle where the shared counter sits at its last value
//   cnt         - shared frame counter (pre-edge value)
//   wr_sel      - load target from wr_on this edge
//   wr_on       - new target on-time
//   enable      - output enable, sampled only at the frame boundary
//   pwm         - registered servo output
module servo_channel
  import servo_pkg::*;
#(
  parameter int unsigned CNT_W    = 21,
  parameter int unsigned SLEW_CYC = 0,
  parameter on_time_t    ON_RESET = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_end,
  input  logic [CNT_W-1:0] cnt,
  input  logic             wr_sel,
  input  on_time_t         wr_on,
  input  logic             enable,
  output logic             pwm
);

  on_time_t target_q, active_q, active_d, diff;
  logic     en_lat_q, pwm_q;

  // Next active value: jump to target unless the distance exceeds the slew limit.
  always_comb begin
    diff     = (target_q > active_q) ? (target_q - active_q) : (active_q - target_q);
    active_d = target_q;
    if ((SLEW_CYC != 0) && (diff > on_time_t'(SLEW_CYC))) begin
      active_d = (target_q > active_q) ? (active_q + on_time_t'(SLEW_CYC))
                                       : (active_q - on_time_t'(SLEW_CYC));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target_q <= ON_RESET;
      active_q <= ON_RESET;
      en_lat_q <= 1'b0;
      pwm_q    <= 1'b0;
    end else begin
      if (wr_sel) begin
        target_q <= wr_on;
      end
      // active_d is built from the pre-edge target, so a same-edge write waits a frame.
      if (frame_end) begin
        active_q <= active_d;
        en_lat_q <= enable;
      end
      pwm_q <= en_lat_q & (on_time_t'(cnt) < active_q);
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/multi_servo_controller.sv
// Multi-channel hobby-servo PWM generator sharing one frame counter.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   enable       - per-channel output enable (takes effect at the next frame)
//   wr_valid     - angle write request; wr_ready is high whenever rst is low
//   wr_ch        - target channel; out-of-range channels are dropped with a wr_err pulse
//   wr_angle     - requested angle, clamped to MAX_ANGLE
//   wr_err       - one-cycle pulse after a dropped write
//   frame_start  - one-cycle pulse coincident with the pwm rising edges
//   pwm          - registered servo outputs
module multi_servo_controller
  import servo_pkg::*;
#(
  parameter int unsigned NUM_CH     = DefNumCh,
  parameter int unsigned ANGLE_W    = DefAngleW,
  parameter int unsigned MAX_ANGLE  = DefMaxAngle,
  parameter int unsigned PERIOD_CYC = DefPeriodCyc,
  parameter int unsigned MIN_ON     = DefMinOn,
  parameter int unsigned STEP_CYC   = DefStepCyc,
  parameter int unsigned SLEW_CYC   = DefSlewCyc,
  localparam int unsigned ChW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_CH-1:0]  enable,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [ChW-1:0]     wr_ch,
  input  logic [ANGLE_W-1:0] wr_angle,
  output logic               wr_err,
  output logic               frame_start,
  output logic [NUM_CH-1:0]  pwm
);

  localparam int unsigned     CntW    = cnt_width(PERIOD_CYC);
  localparam logic [CntW-1:0] CntLast = CntW'(PERIOD_CYC - 1);
  localparam on_time_t        OnReset = angle_to_on(MAX_ANGLE / 2, MAX_ANGLE, MIN_ON, STEP_CYC);

  // A full-angle pulse that reaches the frame length would leave the output stuck high.
  if (MIN_ON + MAX_ANGLE * STEP_CYC >= PERIOD_CYC) begin : g_overrun
    $warning("multi_servo_controller: maximum on-time reaches PERIOD_CYC");
  end

  logic [CntW-1:0] cnt_q;
  logic            frame_end, wr_fire, wr_bad;
  logic            frame_start_q, wr_err_q;
  on_time_t        wr_on;

  assign frame_end = (cnt_q == CntLast);
  assign wr_ready  = ~rst;
  assign wr_fire   = wr_valid & wr_ready;
  assign wr_bad    = (32'(wr_ch) >= NUM_CH);
  assign wr_on     = angle_to_on(32'(wr_angle), MAX_ANGLE, MIN_ON, STEP_CYC);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      frame_start_q <= 1'b0;
      wr_err_q      <= 1'b0;
    end else begin
      cnt_q         <= frame_end ? '0 : cnt_q + 1'b1;
      // Registered from cnt == 0 so it lines up with the registered pwm rise.
      frame_start_q <= (cnt_q == '0);
      wr_err_q      <= wr_fire & wr_bad;
    end
  end

  assign frame_start = frame_start_q;
  assign wr_err      = wr_err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_sel;
    assign wr_sel = wr_fire & ~wr_bad & (wr_ch == ChW'(i));

    servo_channel #(
      .CNT_W    (CntW),
      .SLEW_CYC (SLEW_CYC),
      .ON_RESET (OnReset)
    ) u_channel (
      .clk       (clk),
      .rst       (rst),
      .frame_end (frame_end),
      .cnt       (cnt_q),
      .wr_sel    (wr_sel),
      .wr_on     (wr_on),
      .enable    (enable[i]),
      .pwm       (pwm[i])
    );
  end

endmodule
